// File: rtl/api_tx_arb_pkg.sv
// rtl/api_tx_arb_pkg.sv - shared states, depths and grant encodings for the api tx arbiter
package api_tx_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_PAD  = 2'd2,
      ST_GAP  = 2'd3
   } arb_state_t;

   localparam int TX_DEPTH_DEF = 512;
   localparam int RX_DEPTH_DEF = 256;
   localparam int DATA_W       = 32;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_S0   = 2'b01;
   localparam logic [1:0] GNT_S1   = 2'b10;

   // last_s1 set means s1 was served most recently, so s0 wins a tie
   function automatic logic [1:0] rr_pick(input logic req0, input logic req1, input logic last_s1);
      if (req0 && req1) return last_s1 ? GNT_S0 : GNT_S1;
      else if (req0)    return GNT_S0;
      else if (req1)    return GNT_S1;
      else              return GNT_NONE;
   endfunction
endpackage

// File: rtl/api_tx_arb_if.sv
// rtl/api_tx_arb_if.sv - requester word streams and tx FIFO push port of the api tx arbiter
interface api_tx_arb_if;
   import api_tx_arb_pkg::*;

   logic              s0_req;
   logic              s1_req;
   logic              s0_valid;
   logic              s1_valid;
   logic [DATA_W-1:0] s0_data;
   logic [DATA_W-1:0] s1_data;
   logic              s0_ready;
   logic              s1_ready;
   logic              txfifo_push;
   logic [DATA_W-1:0] txfifo_din;

   modport slave (
      input  s0_req, s1_req, s0_valid, s1_valid, s0_data, s1_data,
      output s0_ready, s1_ready, txfifo_push, txfifo_din
   );

   modport master (
      output s0_req, s1_req, s0_valid, s1_valid, s0_data, s1_data,
      input  s0_ready, s1_ready, txfifo_push, txfifo_din
   );
endinterface

// File: rtl/api_rsv_cnt.sv
// rtl/api_rsv_cnt.sv - rx reply-space reservation counter: add a batch, retire one word per rxpop
module api_rsv_cnt
   import api_tx_arb_pkg::*;
#(
   parameter int RX_DEPTH = RX_DEPTH_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       add_en,
   input  logic [7:0] add_val,
   input  logic       sub_en,
   output logic [8:0] cnt,
   output logic       fits
);
   logic [8:0] r_cnt;
   logic [9:0] w_sum;
   logic [9:0] w_next;

   // add and retire may land together; retiring from an empty counter is dropped
   always_comb begin
      w_sum  = {1'b0, r_cnt} + (add_en ? {2'b00, add_val} : 10'd0);
      w_next = (sub_en && (w_sum != 10'd0)) ? (w_sum - 10'd1) : w_sum;
      if (w_next > 10'(RX_DEPTH))
         w_next = 10'(RX_DEPTH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (clr)
         r_cnt <= '0;
      else
         r_cnt <= w_next[8:0];
   end

   assign fits = ({1'b0, r_cnt} + {2'b00, add_val}) <= 10'(RX_DEPTH);
   assign cnt  = r_cnt;
endmodule

// File: rtl/api_tx_arb.sv
// rtl/api_tx_arb.sv - batch-granting round-robin arbiter in front of the api engine tx FIFO
module api_tx_arb
   import api_tx_arb_pkg::*;
#(
   parameter int          TX_DEPTH  = TX_DEPTH_DEF,
   parameter int          RX_DEPTH  = RX_DEPTH_DEF,
   parameter int          STALL_MAX = 1024,
   parameter logic [31:0] PAD_WORD  = 32'h0
)(
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             flush,
   input  logic [7:0]       cfg_word_num,
   input  logic [9:0]       txcnt,
   input  logic             rxpop,
   api_tx_arb_if.slave      bus,
   output logic [1:0]       grant,
   output logic             busy,
   output logic [8:0]       rsv_cnt,
   output logic             stall_err
);
   localparam int SW = $clog2(STALL_MAX + 1);

   arb_state_t        r_state;
   logic [1:0]        r_grant;
   logic              r_last_s1;
   logic [7:0]        r_blen;
   logic [7:0]        r_wcnt;
   logic [SW-1:0]     r_stall;
   logic              r_push;
   logic [DATA_W-1:0] r_din;
   logic              r_stall_err;

   logic              w_fit_tx;
   logic              w_fit_rx;
   logic              w_elig;
   logic              w_vld;
   logic              w_xfer;
   logic [DATA_W-1:0] w_data;

   // 11-bit sum keeps the tx free-space check clear of underflow
   assign w_fit_tx = ({1'b0, txcnt} + {3'b000, cfg_word_num}) <= 11'(TX_DEPTH);
   assign w_elig   = (r_state == ST_IDLE) && (cfg_word_num != 8'd0) && w_fit_tx && w_fit_rx
                     && (bus.s0_req || bus.s1_req);
   assign w_vld    = r_grant[1] ? bus.s1_valid : bus.s0_valid;
   assign w_data   = r_grant[1] ? bus.s1_data  : bus.s0_data;
   assign w_xfer   = (r_state == ST_XFER) && w_vld;

   api_rsv_cnt #(.RX_DEPTH(RX_DEPTH)) u_rsv (
      .clk     (CLK_I),
      .rst     (RST_I),
      .clr     (flush),
      .add_en  (w_elig),
      .add_val (cfg_word_num),
      .sub_en  (rxpop),
      .cnt     (rsv_cnt),
      .fits    (w_fit_rx)
   );

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I || flush) begin
         r_state     <= ST_IDLE;
         r_grant     <= GNT_NONE;
         r_last_s1   <= 1'b1;
         r_blen      <= '0;
         r_wcnt      <= '0;
         r_stall     <= '0;
         r_push      <= 1'b0;
         r_din       <= '0;
         r_stall_err <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_stall_err <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_elig) begin
               r_state <= ST_XFER;
               r_grant <= rr_pick(bus.s0_req, bus.s1_req, r_last_s1);
               r_blen  <= cfg_word_num;
               r_wcnt  <= '0;
               r_stall <= '0;
            end
            ST_XFER: if (w_xfer) begin
               r_push  <= 1'b1;
               r_din   <= w_data;
               r_stall <= '0;
               r_wcnt  <= r_wcnt + 8'd1;
               if (r_wcnt + 8'd1 == r_blen) begin
                  r_state   <= ST_GAP;
                  r_grant   <= GNT_NONE;
                  r_last_s1 <= r_grant[1];
               end
            end else if (r_stall == SW'(STALL_MAX - 1)) begin
               r_state     <= ST_PAD;
               r_stall     <= '0;
               r_stall_err <= 1'b1;
            end else begin
               r_stall <= r_stall + SW'(1);
            end
            ST_PAD: begin
               r_push <= 1'b1;
               r_din  <= PAD_WORD;
               r_wcnt <= r_wcnt + 8'd1;
               if (r_wcnt + 8'd1 == r_blen) begin
                  r_state   <= ST_GAP;
                  r_grant   <= GNT_NONE;
                  r_last_s1 <= r_grant[1];
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.s0_ready    = (r_state == ST_XFER) && r_grant[0];
   assign bus.s1_ready    = (r_state == ST_XFER) && r_grant[1];
   assign bus.txfifo_push = r_push;
   assign bus.txfifo_din  = r_din;
   assign grant           = r_grant;
   assign busy            = (r_state != ST_IDLE);
   assign stall_err       = r_stall_err;
endmodule

// File: tb/tb_api_tx_arb.sv
// tb/tb_api_tx_arb.sv - vector table plus scoreboarded sequences for api_tx_arb
module tb_api_tx_arb;
   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [7:0] cfg;
   logic [9:0] txcnt;
   logic       rxpop;
   logic [1:0] grant;
   logic       busy;
   logic [8:0] rsv_cnt;
   logic       stall_err;

   api_tx_arb_if bus();

   api_tx_arb dut (
      .CLK_I        (clk),
      .RST_I        (rst),
      .flush        (flush),
      .cfg_word_num (cfg),
      .txcnt        (txcnt),
      .rxpop        (rxpop),
      .bus          (bus),
      .grant        (grant),
      .busy         (busy),
      .rsv_cnt      (rsv_cnt),
      .stall_err    (stall_err)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;
   int n_push = 0;
   int n_stall = 0;
   int idx0 = 0;
   int idx1 = 0;
   int acc0 = 0;
   int acc1 = 0;
   logic [31:0] sb[$];

   typedef struct {
      logic       r0;
      logic       r1;
      logic [7:0] c;
      logic [9:0] tx;
      logic [1:0] g;
   } vec_t;
   vec_t tv[10];

   function automatic logic [31:0] mk(input int s, input int i);
      return 32'hA000_0000 + 32'(s) * 32'h0100_0000 + 32'(i);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.txfifo_push) begin
         n_push++;
         if (sb.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL sb_unexpected: got push %0h want none", bus.txfifo_din);
         end else begin
            chk("sb_word", bus.txfifo_din, sb.pop_front());
         end
      end
      if (stall_err) n_stall++;
   end

   task automatic cycle();
      logic a0, a1;
      a0 = bus.s0_valid & bus.s0_ready;
      a1 = bus.s1_valid & bus.s1_ready;
      if (a0) sb.push_back(bus.s0_data);
      if (a1) sb.push_back(bus.s1_data);
      @(posedge clk);
      #1;
      if (a0) begin idx0++; acc0++; bus.s0_data = mk(0, idx0); end
      if (a1) begin idx1++; acc1++; bus.s1_data = mk(1, idx1); end
      @(negedge clk);
   endtask

   task automatic do_flush();
      bus.s0_req = 0; bus.s1_req = 0; bus.s0_valid = 0; bus.s1_valid = 0;
      rxpop = 0; flush = 1;
      cycle();
      flush = 0; acc0 = 0; acc1 = 0;
   endtask

   initial begin
      logic [1:0] g_first, g_second;
      int base, base_st, k;
      rst = 1; flush = 0; cfg = 0; txcnt = 0; rxpop = 0;
      bus.s0_req = 0; bus.s1_req = 0; bus.s0_valid = 0; bus.s1_valid = 0;
      bus.s0_data = mk(0, 0); bus.s1_data = mk(1, 0);
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsv", 32'(rsv_cnt), 0);
      chk("rst_push", 32'(bus.txfifo_push), 0);
      chk("rst_ready", {30'd0, bus.s1_ready, bus.s0_ready}, 0);
      rst = 0;

      tv[0] = '{1, 0, 8'd23,  10'd0,   2'b01};
      tv[1] = '{0, 1, 8'd23,  10'd0,   2'b10};
      tv[2] = '{1, 1, 8'd23,  10'd0,   2'b01};
      tv[3] = '{0, 0, 8'd23,  10'd0,   2'b00};
      tv[4] = '{1, 1, 8'd0,   10'd0,   2'b00};
      tv[5] = '{1, 0, 8'd23,  10'd500, 2'b00};
      tv[6] = '{1, 0, 8'd23,  10'd489, 2'b01};
      tv[7] = '{1, 0, 8'd23,  10'd490, 2'b00};
      tv[8] = '{0, 1, 8'd255, 10'd257, 2'b10};
      tv[9] = '{1, 0, 8'd255, 10'd0,   2'b01};
      for (int i = 0; i < 10; i++) begin
         do_flush();
         bus.s0_req = tv[i].r0; bus.s1_req = tv[i].r1; cfg = tv[i].c; txcnt = tv[i].tx;
         cycle();
         chk($sformatf("T%0d_grant", i), 32'(grant), 32'(tv[i].g));
         chk($sformatf("T%0d_rsv", i), 32'(rsv_cnt), (tv[i].g != 2'b00) ? 32'(tv[i].c) : 32'd0);
         chk($sformatf("T%0d_busy", i), 32'(busy), (tv[i].g != 2'b00) ? 32'd1 : 32'd0);
      end
      do_flush();
      chk("flush_rsv", 32'(rsv_cnt), 0);
      chk("flush_grant", 32'(grant), 0);
      txcnt = 0;

      // two full batches back to back, s0 first
      cfg = 23; bus.s0_req = 1; bus.s1_req = 1; bus.s0_valid = 1; bus.s1_valid = 1;
      g_first = 0; g_second = 0; base = n_push;
      for (int i = 0; i < 200 && (n_push - base) < 46; i++) begin
         cycle();
         if (grant != 2'b00 && g_first == 2'b00) g_first = grant;
         if (grant == 2'b10) begin g_second = grant; bus.s0_req = 0; bus.s1_req = 0; end
      end
      repeat (3) cycle();
      chk("A_first", 32'(g_first), 32'h1);
      chk("A_second", 32'(g_second), 32'h2);
      chk("A_pushes", 32'(n_push - base), 46);
      chk("A_rsv", 32'(rsv_cnt), 46);
      chk("A_grant_end", 32'(grant), 0);
      chk("A_sb_empty", 32'(sb.size()), 0);

      // tx space boundary
      do_flush();
      cfg = 23; txcnt = 500; bus.s0_req = 1;
      repeat (3) cycle();
      chk("B_nogrant", 32'(grant), 0);
      txcnt = 489;
      cycle();
      chk("B_grant", 32'(grant), 32'h1);
      txcnt = 0;

      // rx reservation boundary
      do_flush();
      cfg = 240; bus.s0_req = 1; bus.s0_valid = 1;
      for (int i = 0; i < 300 && acc0 < 240; i++) cycle();
      bus.s0_valid = 0;
      repeat (3) cycle();
      chk("C_rsv240", 32'(rsv_cnt), 240);
      cfg = 23;
      repeat (3) cycle();
      chk("C_nogrant", 32'(grant), 0);
      rxpop = 1;
      repeat (7) cycle();
      rxpop = 0;
      chk("C_rsv233", 32'(rsv_cnt), 233);
      chk("C_grant_wait", 32'(grant), 0);
      cycle();
      chk("C_grant", 32'(grant), 32'h1);
      chk("C_rsv256", 32'(rsv_cnt), 256);

      // grant coincident with rxpop
      do_flush();
      cfg = 10; bus.s0_req = 1; bus.s0_valid = 1;
      for (int i = 0; i < 40 && acc0 < 10; i++) begin
         cycle();
         if (grant != 2'b00) bus.s0_req = 0;
      end
      bus.s0_valid = 0;
      repeat (3) cycle();
      chk("D_rsv10", 32'(rsv_cnt), 10);
      cfg = 23; bus.s0_req = 1; rxpop = 1;
      cycle();
      rxpop = 0; bus.s0_req = 0;
      chk("D_grant", 32'(grant), 32'h1);
      chk("D_rsv32", 32'(rsv_cnt), 32);

      // stall then padding on s1
      do_flush();
      repeat (2) cycle();
      base = n_push; base_st = n_stall;
      cfg = 23; bus.s1_req = 1; bus.s1_valid = 1;
      for (int i = 0; i < 50 && acc1 < 5; i++) begin
         cycle();
         if (grant != 2'b00) bus.s1_req = 0;
      end
      bus.s1_valid = 0;
      for (int i = 0; i < 18; i++) sb.push_back(32'h0);
      k = 0;
      for (int i = 0; i < 1100; i++) begin
         cycle();
         k++;
         if (stall_err) break;
      end
      chk("E_stall_latency", 32'(k), 1024);
      repeat (25) cycle();
      chk("E_pushes", 32'(n_push - base), 23);
      chk("E_stall_pulses", 32'(n_stall - base_st), 1);
      chk("E_sb_empty", 32'(sb.size()), 0);
      chk("E_grant_end", 32'(grant), 0);

      // async reset in the middle of a batch
      do_flush();
      cfg = 23; bus.s0_req = 1; bus.s0_valid = 1;
      for (int i = 0; i < 40 && acc0 < 7; i++) cycle();
      bus.s0_valid = 0;
      cycle();
      chk("F_busy_pre", 32'(busy), 1);
      #2 rst = 1;
      #1;
      chk("F_grant", 32'(grant), 0);
      chk("F_busy", 32'(busy), 0);
      chk("F_rsv", 32'(rsv_cnt), 0);
      chk("F_ready", {30'd0, bus.s1_ready, bus.s0_ready}, 0);
      chk("F_push", 32'(bus.txfifo_push), 0);
      chk("F_sb_empty", 32'(sb.size()), 0);
      @(negedge clk);
      rst = 0;
      bus.s0_req = 1; bus.s1_req = 1;
      cycle();
      chk("F_s0_first", 32'(grant), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/api_tx_arb.md
Name: api_tx_arb

Overview:
- Shares the API engine's tx FIFO between two word-stream requesters: s0 (CPU/wishbone path) and s1 (hardware work generator).
- Grants one requester for a whole batch of cfg_word_num words so batches never interleave, then pushes those words into the tx FIFO.
- Admits a batch only when the tx FIFO has room for it and the rx FIFO has unreserved space for the matching reply. This keeps the API engine from overflowing rx.
- Sits between the requesters and the tx FIFO push port, in place of the direct slave push.

Parameters:
- TX_DEPTH, 512, tx FIFO depth in words.
- RX_DEPTH, 256, rx FIFO depth in words.
- STALL_MAX, 1024, cycles a granted source may withhold valid before padding starts.
- PAD_WORD, 32'h0, word pushed when padding.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear; same effect as reset, one cycle.
- cfg_word_num  in  8  words per batch; 0 disables granting.
- s0_req, s1_req  in  1 each  requester has a batch pending.
- s0_valid, s1_valid  in  1 each  data word valid.
- s0_data, s1_data  in  32 each  data word.
- s0_ready, s1_ready  out  1 each  word accepted; asserted only for the granted source, in XFER.
- txfifo_push  out  1  tx FIFO write enable.
- txfifo_din  out  32  tx FIFO write data.
- txcnt  in  10  tx FIFO data_count.
- rxpop  in  1  rx FIFO read strobe (one reply word consumed).
- grant  out  2  one-hot current owner; 00 when none.
- busy  out  1  state != IDLE.
- rsv_cnt  out  9  rx words currently reserved.
- stall_err  out  1  one-cycle pulse when a batch is padded.

Behaviour:
- Reset or flush: state IDLE, grant=00, rsv_cnt=0, word counter=0, stall counter=0, last-served=s1 (so s0 wins first). All outputs 0.
- FSM states: IDLE, XFER, PAD, GAP.
- Eligibility (evaluated in IDLE only), eligible when all hold:
  - cfg_word_num != 0;
  - (TX_DEPTH - txcnt) >= cfg_word_num;
  - (RX_DEPTH - rsv_cnt) >= cfg_word_num;
  - at least one sN_req is set.
- Arbitration, IDLE -> XFER when eligible:
  - Round-robin; the source not served last wins on a tie.
  - grant is registered, visible the cycle after eligibility.
  - cfg_word_num is latched into blen at grant; later changes affect only the next batch.
  - rsv_cnt += blen on the grant cycle.
- XFER:
  - sN_ready = 1 for the granted N. A word transfers when valid & ready.
  - txfifo_push / txfifo_din are registered, one cycle after the transfer.
  - Word counter increments per transfer. On word blen: -> GAP, grant=00, last-served=N.
  - Stall counter resets on each transfer and counts cycles with valid low. When it reaches STALL_MAX: -> PAD, stall_err pulses.
- PAD:
  - Ready deasserted.
  - Pushes PAD_WORD once per cycle until blen words total, then -> GAP.
- GAP:
  - One cycle, lets txcnt settle after the final push, then -> IDLE.
  - Minimum batch-to-batch spacing is therefore 2 cycles.
- rsv_cnt update:
  - Decrements by 1 on rxpop; saturates at 0, never wraps.
  - Grant and rxpop in the same cycle: rsv_cnt + blen - 1.
  - rsv_cnt never exceeds RX_DEPTH.
- Source protocol:
  - sN_req dropping mid-batch does not release the grant; only word count or padding ends a batch.
  - Ungranted sN_valid is ignored.
- Reset mid-XFER: partial batch abandoned immediately. The tx FIFO is cleared by the same reset (shared rst), so no partial batch remains.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/XFER/PAD/GAP);
  - TX_DEPTH/RX_DEPTH defaults, matching the api FIFO sizes;
  - grant one-hot constants.
- One natural sub-module: api_rsv_cnt, the saturating reservation counter with add-blen/sub-1 and free-space compare. The FSM and round-robin stay in the top.

Test Plan:
- Both req set, cfg_word_num=23, both valid always high:
  - s0 granted first; 23 pushes of s0 data; GAP; then s1 granted; 23 pushes.
  - rsv_cnt=46.
- txcnt=500, cfg_word_num=23, s0_req=1:
  - No grant (12 free < 23).
  - Lower txcnt to 489: grant=01 next cycle.
- rsv_cnt reaching 240 with cfg_word_num=23:
  - No grant.
  - Pulse rxpop 7 times (rsv_cnt=233): grant issued; rsv_cnt=256.
- s1 granted, sends 5 words, then valid low for STALL_MAX cycles:
  - stall_err pulses once; 18 PAD_WORD pushes follow; total 23 pushes.
- Grant cycle coincident with rxpop, rsv_cnt=10, blen=23 -> rsv_cnt=32 next cycle.
- RST_I asserted mid-XFER after 7 words:
  - Outputs 0 and grant=00 immediately (async), rsv_cnt=0.
  - After release, s0 wins the next arbitration.
